// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM sweep controller: data width, write-select
// encodings and controller states.
package pwm_pkg;

  localparam int unsigned PWM_W = 16;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CMP  = 2'd1;
  localparam logic [1:0] SEL_TOP  = 2'd2;
  localparam logic [1:0] SEL_CNT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TOP,
    SYNC,
    LOAD_LO,
    UP,
    DOWN
  } state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// Counts PWM period ends (cnt >= top) and emits a one-cycle step_tick
// on every pps-th period end while enabled.
module pwm_period_tick #(
  parameter int unsigned W  = 16,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  pwm_cnt,
  input  logic [W-1:0]  top,
  input  logic [PW-1:0] pps,
  output logic          step_tick
);

  logic [PW-1:0] cnt;
  logic          period_end;

  assign period_end = en && (pwm_cnt >= top);
  // pps is never 0 here, so pps-1 is a reachable terminal count
  assign step_tick  = period_end && (cnt == PW'(pps - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (period_end) begin
      cnt <= step_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// Command sequencer for the PWM counter block: programs TOP, resyncs CNT,
// then sweeps CMP lo->hi->lo one step every pps PWM periods.
module pwm_sweep_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned W  = PWM_W,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  cfg_top,
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic [W-1:0]  cfg_step,
  input  logic [PW-1:0] cfg_pps,
  input  logic [PW-1:0] cfg_sweeps,
  input  logic [W-1:0]  pwm_cnt,
  output logic [W-1:0]  d,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  cur_cmp
);

  state_t        state, state_n;
  logic [W-1:0]  top_r, lo_r, hi_r, step_r;
  logic [PW-1:0] pps_r, sweeps_r, sweep_cnt;

  logic [W-1:0]  d_n, cmp_n;
  logic [1:0]    sel_n;
  logic          busy_n, done_n;
  logic [PW-1:0] sweep_n;

  logic          accept, step_tick, complete, run_en;
  logic [W:0]    up_sum, lo_plus;
  logic [PW-1:0] sweep_inc;
  logic          last_sweep;

  assign accept     = (state == IDLE) && !busy && start && !abort;
  assign run_en     = (state == UP) || (state == DOWN);
  assign up_sum     = {1'b0, cur_cmp} + {1'b0, step_r};
  assign lo_plus    = {1'b0, lo_r} + {1'b0, step_r};
  assign sweep_inc  = sweep_cnt + 1'b1;
  assign last_sweep = (sweeps_r != '0) && (sweep_inc == sweeps_r);

  pwm_period_tick #(.W(W), .PW(PW)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (run_en),
    .pwm_cnt   (pwm_cnt),
    .top       (top_r),
    .pps       (pps_r),
    .step_tick (step_tick)
  );

  always_comb begin
    state_n  = state;
    sel_n    = SEL_NONE;
    d_n      = '0;
    busy_n   = busy;
    done_n   = 1'b0;
    cmp_n    = cur_cmp;
    sweep_n  = sweep_cnt;
    complete = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (accept) begin
          state_n = LOAD_TOP;
          sel_n   = SEL_TOP;
          d_n     = cfg_top;
          busy_n  = 1'b1;
          sweep_n = '0;
        end
      end
      LOAD_TOP: begin
        state_n = SYNC;
        sel_n   = SEL_CNT;
      end
      SYNC: begin
        state_n = LOAD_LO;
        sel_n   = SEL_CMP;
        d_n     = lo_r;
        cmp_n   = lo_r;
      end
      LOAD_LO: state_n = UP;
      UP: begin
        if (step_tick) begin
          if (lo_r == hi_r) begin
            complete = 1'b1;
          end else if (up_sum >= {1'b0, hi_r}) begin
            state_n = DOWN;
            sel_n   = SEL_CMP;
            d_n     = hi_r;
            cmp_n   = hi_r;
          end else begin
            sel_n = SEL_CMP;
            d_n   = up_sum[W-1:0];
            cmp_n = up_sum[W-1:0];
          end
        end
      end
      DOWN: begin
        if (step_tick) begin
          if ({1'b0, cur_cmp} <= lo_plus) begin
            complete = 1'b1;
          end else begin
            sel_n = SEL_CMP;
            d_n   = cur_cmp - step_r;
            cmp_n = cur_cmp - step_r;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Writing lo closes a sweep; busy stays high through this final write
    if (complete) begin
      sel_n   = SEL_CMP;
      d_n     = lo_r;
      cmp_n   = lo_r;
      sweep_n = sweep_inc;
      if (last_sweep) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = UP;
      end
    end

    if (abort) begin
      state_n = IDLE;
      sel_n   = SEL_NONE;
      d_n     = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      cmp_n   = cur_cmp;
      sweep_n = sweep_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d         <= '0;
      sel       <= SEL_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_cmp   <= '0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_n;
      d         <= d_n;
      sel       <= sel_n;
      busy      <= busy_n;
      done      <= done_n;
      cur_cmp   <= cmp_n;
      sweep_cnt <= sweep_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_r    <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      step_r   <= '1;
      pps_r    <= PW'(1);
      sweeps_r <= '0;
    end else if (accept) begin
      top_r    <= cfg_top;
      lo_r     <= cfg_lo;
      hi_r     <= (cfg_lo > cfg_hi) ? cfg_lo : cfg_hi;
      step_r   <= (cfg_step == '0) ? W'(1) : cfg_step;
      pps_r    <= (cfg_pps == '0) ? PW'(1) : cfg_pps;
      sweeps_r <= cfg_sweeps;
    end
  end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// Scoreboard bench for pwm_sweep_ctrl with a behavioural PWM counter attached.
module tb_pwm_sweep_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cfg_top = '0, cfg_lo = '0, cfg_hi = '0, cfg_step = '0;
  logic [PW-1:0] cfg_pps = '0, cfg_sweeps = '0;
  logic [W-1:0]  pwm_cnt, d, cur_cmp;
  logic [1:0]    sel;
  logic          busy, done;

  pwm_sweep_ctrl #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_top(cfg_top), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step),
    .cfg_pps(cfg_pps), .cfg_sweeps(cfg_sweeps), .pwm_cnt(pwm_cnt),
    .d(d), .sel(sel), .busy(busy), .done(done), .cur_cmp(cur_cmp)
  );

  always #5 clk = ~clk;

  // PWM block: wraps when cnt >= top, write port d/sel, unaffected by rst
  logic [W-1:0] m_cnt = '0, m_top = '0, m_cmp = '0;
  assign pwm_cnt = m_cnt;
  always @(posedge clk) begin
    if (sel == 2'd3)        m_cnt <= d;
    else if (m_cnt >= m_top) m_cnt <= '0;
    else                    m_cnt <= m_cnt + 1'b1;
    if (sel == 2'd2) m_top <= d;
    if (sel == 2'd1) m_cmp <= d;
  end

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] d;
    logic         done;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned wtimes[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sel != 2'd0) begin
        if (sel == 2'd1) wtimes.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got sel=%0d d=%h done=%0d, expected no write", sel, d, done);
        end else begin
          e = exp_q.pop_front();
          if ({sel, d, done} !== e) begin
            errors++;
            $display("FAIL write: got sel=%0d d=%h done=%0d, expected sel=%0d d=%h done=%0d",
                     sel, d, done, e.sel, e.d, e.done);
          end
        end
      end else if (d != '0 || done) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs: got d=%h done=%0d with sel=0, expected d=0 done=0", d, done);
      end
    end
  end

  task automatic push(input logic [1:0] s, input logic [W-1:0] v, input logic dn);
    exp_q.push_back(exp_t'{s, v, dn});
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic go(input logic [W-1:0] t, input logic [W-1:0] l, input logic [W-1:0] h,
                    input logic [W-1:0] s, input logic [PW-1:0] p, input logic [PW-1:0] n);
    @(negedge clk);
    cfg_top = t; cfg_lo = l; cfg_hi = h; cfg_step = s; cfg_pps = p; cfg_sweeps = n;
    wtimes.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending writes, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check({name, "_busy"}, W'(busy), '0);
  endtask

  task automatic check_spacing(input string name, input int first, input int last, input int gap);
    if (wtimes.size() <= last) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d CMP writes, expected %0d", name, wtimes.size(), last + 1);
    end else begin
      for (int i = first + 1; i <= last; i++)
        check(name, W'(wtimes[i] - wtimes[i-1]), W'(gap));
    end
  endtask

  initial begin
    #2;
    check("rst_sel", W'(sel), '0);
    check("rst_d", d, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_cur_cmp", cur_cmp, '0);
    @(negedge clk);
    rst = 1'b0;

    // Triangle sweep: 4, 6, 4, 2 at successive period ends (period 10)
    push(2, 16'd9, 0); push(3, 16'd0, 0); push(1, 16'd2, 0);
    push(1, 16'd4, 0); push(1, 16'd6, 0); push(1, 16'd4, 0); push(1, 16'd2, 1);
    go(16'd9, 16'd2, 16'd6, 16'd2, 8'd1, 8'd1);
    wait_empty("triangle", 200);
    wait_idle("triangle");
    check("triangle_cur_cmp", cur_cmp, 16'd2);
    check_spacing("triangle_gap", 1, 4, 10);

    // Full-range step: clamps at 0xFFFF going up, no underflow coming down
    push(2, 16'd3, 0); push(3, 16'd0, 0); push(1, 16'h0000, 0);
    push(1, 16'hC000, 0); push(1, 16'hFFFF, 0); push(1, 16'h3FFF, 0); push(1, 16'h0000, 1);
    go(16'd3, 16'h0000, 16'hFFFF, 16'hC000, 8'd1, 8'd1);
    wait_empty("wide", 200);
    wait_idle("wide");

    // pps=3, top=4: step writes 15 cycles apart
    push(2, 16'd4, 0); push(3, 16'd0, 0); push(1, 16'd0, 0);
    push(1, 16'd1, 0); push(1, 16'd2, 0); push(1, 16'd3, 0);
    push(1, 16'd2, 0); push(1, 16'd1, 0); push(1, 16'd0, 1);
    go(16'd4, 16'd0, 16'd3, 16'd1, 8'd3, 8'd1);
    wait_empty("pps3", 400);
    wait_idle("pps3");
    check_spacing("pps3_gap", 1, 6, 15);

    // pps=0 must act as pps=1
    push(2, 16'd9, 0); push(3, 16'd0, 0); push(1, 16'd2, 0);
    push(1, 16'd4, 0); push(1, 16'd6, 0); push(1, 16'd4, 0); push(1, 16'd2, 1);
    go(16'd9, 16'd2, 16'd6, 16'd2, 8'd0, 8'd1);
    wait_empty("pps0", 200);
    wait_idle("pps0");
    check_spacing("pps0_gap", 1, 4, 10);

    // start and cfg_hi changes while busy are ignored
    push(2, 16'd9, 0); push(3, 16'd0, 0); push(1, 16'd2, 0);
    push(1, 16'd4, 0); push(1, 16'd6, 0); push(1, 16'd4, 0); push(1, 16'd2, 0);
    push(1, 16'd4, 0); push(1, 16'd6, 0); push(1, 16'd4, 0); push(1, 16'd2, 1);
    go(16'd9, 16'd2, 16'd6, 16'd2, 8'd1, 8'd2);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() <= 8) break;
      @(negedge clk);
    end
    cfg_hi = 16'd8; cfg_top = 16'd5; cfg_lo = 16'd1; cfg_sweeps = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("busy_start", 300);
    wait_idle("busy_start");
    check("busy_start_cur_cmp", cur_cmp, 16'd2);

    // Endless run: 5 sweeps plus one step, then abort on a step tick
    push(2, 16'd3, 0); push(3, 16'd0, 0); push(1, 16'd0, 0);
    for (int s = 0; s < 5; s++) begin
      push(1, 16'd1, 0); push(1, 16'd2, 0); push(1, 16'd1, 0); push(1, 16'd0, 0);
    end
    push(1, 16'd1, 0);
    go(16'd3, 16'd0, 16'd2, 16'd1, 8'd1, 8'd0);
    wait_empty("endless", 300);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_cnt >= m_top) break;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_busy", W'(busy), '0);
    check("abort_sel", W'(sel), '0);
    check("abort_cur_cmp", cur_cmp, 16'd1);

    // Asynchronous reset while a CMP write is on the port
    push(2, 16'd9, 0); push(3, 16'd0, 0); push(1, 16'd2, 0); push(1, 16'd4, 0);
    go(16'd9, 16'd2, 16'd6, 16'd2, 8'd1, 8'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sel == 2'd1 && d == 16'd4) break;
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_sel", W'(sel), '0);
    check("midrst_busy", W'(busy), '0);
    check("midrst_cur_cmp", cur_cmp, '0);
    check("midrst_d", d, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_empty("midrst", 2);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
